// File: rtl/elevator_plant_model_pkg.sv
// Shared types and constants for the elevator plant model.
// Covers the door and motion states, the floor geometry and the fault bit positions.
package elevator_pkg;

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_state_t;
    typedef enum logic [1:0] {STOP, UP, DOWN} motion_t;

    localparam int FLOOR_W    = 2;
    localparam int NUM_FLOORS = 4;

    localparam int F_BOTH = 0;  // both motors commanded
    localparam int F_DOOR = 1;  // motor on while door not closed
    localparam int F_TOP  = 2;  // drove up past the top floor
    localparam int F_BOT  = 3;  // drove down past the ground floor

endpackage

// File: rtl/elevator_plant_model_if.sv
// Controller <-> plant signal bundle.
// The controller (master) drives the motor and door commands; the plant (slave) returns the sensors.
interface elevator_plant_model_if;
    logic       motor1;
    logic       motor2;
    logic       porta;
    logic       sen1;
    logic       sen2;
    logic       sen3;
    logic       sen4;
    logic       door_closed;
    logic       door_open;
    logic [1:0] floor_idx;
    logic [7:0] offset;
    logic [3:0] fault;

    modport master (
        output motor1, motor2, porta,
        input  sen1, sen2, sen3, sen4, door_closed, door_open, floor_idx, offset, fault
    );

    modport slave (
        input  motor1, motor2, porta,
        output sen1, sen2, sen3, sen4, door_closed, door_open, floor_idx, offset, fault
    );
endinterface

// File: rtl/elevator_plant_model_door.sv
// Door FSM. In OPENING/CLOSING the counter holds how far the door is open (1..DOOR_TICKS-1),
// so a reversal simply walks the same counter back and retraces the partial travel.
module plant_door_timer
    import elevator_pkg::*;
#(
    parameter int DOOR_TICKS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic porta,
    input  logic motor_active,
    output logic door_closed,
    output logic door_open
);
    localparam int CW = (DOOR_TICKS < 2) ? 1 : $clog2(DOOR_TICKS);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(DOOR_TICKS - 1);

    door_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          closed_q, open_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLOSED: if (porta && !motor_active) begin
                if (DOOR_TICKS == 1) state_d = OPEN;
                else begin
                    state_d = OPENING;
                    cnt_d   = ONE;
                end
            end
            OPENING, CLOSING: if (porta) begin
                if (cnt_q == LAST) state_d = OPEN;
                else begin
                    state_d = OPENING;
                    cnt_d   = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == ONE) state_d = CLOSED;
                else begin
                    state_d = CLOSING;
                    cnt_d   = cnt_q - ONE;
                end
            end
            OPEN: if (!porta) begin
                if (DOOR_TICKS == 1) state_d = CLOSED;
                else begin
                    state_d = CLOSING;
                    cnt_d   = LAST;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CLOSED;
            cnt_q    <= '0;
            closed_q <= 1'b1;
            open_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            closed_q <= (state_d == CLOSED);
            open_q   <= (state_d == OPEN);
        end
    end

    assign door_closed = closed_q;
    assign door_open   = open_q;
endmodule

// File: rtl/elevator_plant_model.sv
// Cabin/shaft plant: integrates the motor commands into a floor+offset position,
// raises sticky faults on illegal commands and reports registered floor sensors.
module elevator_plant_model
    import elevator_pkg::*;
#(
    parameter int TRAVEL_TICKS = 50,
    parameter int DOOR_TICKS   = 10,
    parameter int INIT_FLOOR   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    elevator_plant_model_if.slave  bus
);
    localparam logic [7:0]            LAST_OFF  = 8'(TRAVEL_TICKS - 1);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    HOME      = FLOOR_W'(INIT_FLOOR);
    localparam logic [NUM_FLOORS-1:0] HOME_SEN  = NUM_FLOORS'(1) << INIT_FLOOR;

    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [7:0]            off_q, off_d;
    logic [3:0]            fault_q, fault_d;
    logic [NUM_FLOORS-1:0] sen_q, sen_d;
    logic                  door_closed, door_open;
    motion_t               motion;

    plant_door_timer #(.DOOR_TICKS(DOOR_TICKS)) u_door (
        .clock        (clock),
        .reset        (reset),
        .porta        (bus.porta),
        .motor_active (bus.motor1 | bus.motor2),
        .door_closed  (door_closed),
        .door_open    (door_open)
    );

    // Interlock: any latched fault or a door that is not fully closed pins the cabin.
    always_comb begin
        motion = STOP;
        if (fault_q == '0 && door_closed) begin
            if (bus.motor2 && !bus.motor1)      motion = UP;
            else if (bus.motor1 && !bus.motor2) motion = DOWN;
        end
    end

    always_comb begin
        floor_d = floor_q;
        off_d   = off_q;
        fault_d = fault_q;
        if (bus.motor1 && bus.motor2)                  fault_d[F_BOTH] = 1'b1;
        if ((bus.motor1 || bus.motor2) && !door_closed) fault_d[F_DOOR] = 1'b1;
        case (motion)
            UP: begin
                if (floor_q == TOP_FLOOR && off_q == '0) fault_d[F_TOP] = 1'b1;
                else if (off_q == LAST_OFF) begin
                    floor_d = floor_q + FLOOR_W'(1);
                    off_d   = '0;
                end else off_d = off_q + 8'd1;
            end
            DOWN: begin
                if (off_q != '0) off_d = off_q - 8'd1;
                else if (floor_q == '0) fault_d[F_BOT] = 1'b1;
                else begin
                    floor_d = floor_q - FLOOR_W'(1);
                    off_d   = LAST_OFF;
                end
            end
            default: ;
        endcase
        for (int k = 0; k < NUM_FLOORS; k++)
            sen_d[k] = (floor_d == FLOOR_W'(k)) && (off_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            floor_q <= HOME;
            off_q   <= '0;
            fault_q <= '0;
            sen_q   <= HOME_SEN;
        end else begin
            floor_q <= floor_d;
            off_q   <= off_d;
            fault_q <= fault_d;
            sen_q   <= sen_d;
        end
    end

    assign bus.sen1        = sen_q[0];
    assign bus.sen2        = sen_q[1];
    assign bus.sen3        = sen_q[2];
    assign bus.sen4        = sen_q[3];
    assign bus.door_closed = door_closed;
    assign bus.door_open   = door_open;
    assign bus.floor_idx   = floor_q;
    assign bus.offset      = off_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_elevator_plant_model.sv
// Bench for elevator_plant_model: directed vector table plus random command segments,
// every cycle compared against an absolute-position / door-travel reference model.
module tb_elevator_plant_model;
    localparam int T    = 50;
    localparam int D    = 10;
    localparam int INIT = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elevator_plant_model_if bus ();

    elevator_plant_model #(.TRAVEL_TICKS(T), .DOOR_TICKS(D), .INIT_FLOOR(INIT)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       rst, m1, m2, pa;
        int         n;
        logic [3:0] sen;
        logic       cl, op;
        logic [1:0] fl;
        int         off;
        logic [3:0] flt;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: cabin as an absolute tick height, door as how far open (0..D).
    int         pos;
    int         dx;
    logic [3:0] mf;

    task automatic model_edge();
        logic [3:0] nf;
        logic       closed;
        logic       m1, m2;
        m1 = bus.motor1;
        m2 = bus.motor2;
        if (rst) begin
            pos = INIT * T;
            dx  = 0;
            mf  = '0;
            return;
        end
        nf     = mf;
        closed = (dx == 0);
        if (m1 && m2) nf[0] = 1'b1;
        if ((m1 || m2) && !closed) nf[1] = 1'b1;
        if (mf == 0 && closed && m2 && !m1) begin
            if (pos == 3 * T) nf[2] = 1'b1;
            else pos++;
        end else if (mf == 0 && closed && m1 && !m2) begin
            if (pos == 0) nf[3] = 1'b1;
            else pos--;
        end
        if (bus.porta) begin
            if (dx < D && !(dx == 0 && (m1 || m2))) dx++;
        end else if (dx > 0) dx--;
        mf = nf;
    endtask

    function automatic logic [19:0] model_obs();
        logic [3:0] s;
        int fl, of;
        s  = '0;
        fl = pos / T;
        of = pos % T;
        if (of == 0) s[fl] = 1'b1;
        return {s, dx == 0, dx == D, 2'(fl), 8'(of), mf};
    endfunction

    function automatic logic [19:0] dut_obs();
        return {bus.sen4, bus.sen3, bus.sen2, bus.sen1, bus.door_closed, bus.door_open,
                bus.floor_idx, bus.offset, bus.fault};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (sen4..1,cl,op,floor,offset,fault)", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m1, input logic m2, input logic pa);
        rst        = r;
        bus.motor1 = m1;
        bus.motor2 = m2;
        bus.porta  = pa;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("model", dut_obs(), model_obs());
        end
    endtask

    task automatic add(input logic r, input logic m1, input logic m2, input logic pa, input int n,
                       input logic [3:0] sen, input logic cl, input logic op,
                       input logic [1:0] fl, input int off, input logic [3:0] flt);
        vec_t v;
        v.rst = r; v.m1 = m1; v.m2 = m2; v.pa = pa; v.n = n;
        v.sen = sen; v.cl = cl; v.op = op; v.fl = fl; v.off = off; v.flt = flt;
        tbl.push_back(v);
    endtask

    initial begin
        int k, n;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        pos = 0; dx = 0; mf = '0;

        //  rst m1 m2 pa  n    sen     cl op fl off fault
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 1, 0, 1,   4'b0000, 1, 0, 0, 1,  4'b0000);
        add(0, 0, 1, 0, 48,  4'b0000, 1, 0, 0, 49, 4'b0000);
        add(0, 0, 1, 0, 1,   4'b0010, 1, 0, 1, 0,  4'b0000);
        add(0, 0, 1, 0, 100, 4'b1000, 1, 0, 3, 0,  4'b0000);
        add(0, 0, 1, 0, 5,   4'b1000, 1, 0, 3, 0,  4'b0100);
        add(0, 1, 0, 0, 3,   4'b1000, 1, 0, 3, 0,  4'b0100);
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 1, 0, 50,  4'b0010, 1, 0, 1, 0,  4'b0000);
        add(0, 0, 0, 1, 1,   4'b0010, 0, 0, 1, 0,  4'b0000);
        add(0, 0, 0, 1, 8,   4'b0010, 0, 0, 1, 0,  4'b0000);
        add(0, 0, 0, 1, 1,   4'b0010, 0, 1, 1, 0,  4'b0000);
        add(0, 1, 0, 1, 1,   4'b0010, 0, 1, 1, 0,  4'b0010);
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 1, 0, 100, 4'b0100, 1, 0, 2, 0,  4'b0000);
        add(0, 1, 1, 0, 1,   4'b0100, 1, 0, 2, 0,  4'b0001);
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 1, 4,   4'b0001, 0, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 0, 3,   4'b0001, 0, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 1, 0, 100, 4'b0100, 1, 0, 2, 0,  4'b0000);
        add(0, 1, 0, 0, 27,  4'b0000, 1, 0, 1, 23, 4'b0000);
        add(1, 1, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 1, 5,   4'b0001, 0, 0, 0, 0,  4'b0000);
        add(1, 0, 0, 1, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 1, 10,  4'b0001, 0, 1, 0, 0,  4'b0000);
        add(0, 0, 0, 0, 3,   4'b0001, 0, 0, 0, 0,  4'b0000);
        add(0, 0, 0, 1, 3,   4'b0001, 0, 1, 0, 0,  4'b0000);
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 0, 1, 1, 2,   4'b0000, 1, 0, 0, 2,  4'b0000);
        add(1, 0, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b0000);
        add(0, 1, 0, 0, 1,   4'b0001, 1, 0, 0, 0,  4'b1000);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].m1, tbl[i].m2, tbl[i].pa);
            step(tbl[i].n);
            chk($sformatf("vec%0d", i), dut_obs(),
                {tbl[i].sen, tbl[i].cl, tbl[i].op, tbl[i].fl, 8'(tbl[i].off), tbl[i].flt});
        end

        // Random command segments; latched faults are usually cleared to keep the cabin moving.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        for (int s = 0; s < 80; s++) begin
            k = $urandom_range(0, 99);
            n = $urandom_range(1, 120);
            if (mf != 0 && $urandom_range(0, 2) != 0) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                step(1);
            end
            if (k < 35)      drive(1'b0, 1'b0, 1'b1, 1'b0);
            else if (k < 60) drive(1'b0, 1'b1, 1'b0, 1'b0);
            else if (k < 75) drive(1'b0, 1'b0, 1'b0, 1'b1);
            else if (k < 88) drive(1'b0, 1'b0, 1'b0, 1'b0);
            else if (k < 93) drive(1'b0, 1'b1, 1'b1, 1'b0);
            else if (k < 97) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            else begin
                drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                n = 1;
            end
            step(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
